// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// ram_ctrl_pkg : shared types for the 16x8 output-RAM controller   (rev 1.0)
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    ACCESS  = 2'd2,
    RD_WAIT = 2'd3
  } ctrl_state_t;

  // Sized by the package defaults; resize here together with the top parameters.
  typedef struct packed {
    logic                      id;
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-requester arbiter, round-robin when RAM_OUTPUT_CTRL_RR_EN is
//           defined, fixed priority (requester 0) otherwise        (rev 1.0)
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

`ifdef RAM_OUTPUT_CTRL_RR_EN
  // ptr_q names the requester that won last; it starts at 1 so 0 wins first.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr_q ? 2'b01 : 2'b10;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00)) ptr_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end
`else
  logic unused_arb_inputs;

  assign unused_arb_inputs = ^{clk, rst_n, advance};

  always_comb begin
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_output_ctrl.sv
// ============================================================================
// ram_output_ctrl : zero-fills the output RAM after reset, then serves two
//                   req/ack requesters on the single RAM port. Arbitration
//                   mode chosen by RAM_OUTPUT_CTRL_RR_EN.          (rev 1.0)
// ============================================================================
`default_nettype none

module ram_output_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ctrl_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  init_done_q, init_done_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       arb_advance;

  // A requester is still dropping req during its ack cycle, so mask it out.
  assign arb_req     = {req1 & ~ack1_q, req0 & ~ack0_q};
  assign arb_advance = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    cmd_d       = cmd_q;
    init_done_d = init_done_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata_d     = rdata_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;

    unique case (state_q)
      INIT: begin
        // Fill ends once the last address has been presented with we high.
        if (ram_we_q && (ram_addr_q == LAST_ADDR)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = fill_cnt_q;
          ram_data_d = '0;
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (arb_gnt != 2'b00) begin
          cmd_d.id    = arb_gnt[1];
          cmd_d.we    = arb_gnt[1] ? we1    : we0;
          cmd_d.addr  = arb_gnt[1] ? addr1  : addr0;
          cmd_d.wdata = arb_gnt[1] ? wdata1 : wdata0;
          ram_we_d    = cmd_d.we;
          ram_addr_d  = cmd_d.addr;
          ram_data_d  = cmd_d.wdata;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cmd_q.we) begin
          ack0_d  = ~cmd_q.id;
          ack1_d  = cmd_q.id;
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        rdata_d = ram_q;
        ack0_d  = ~cmd_q.id;
        ack1_d  = cmd_q.id;
        state_d = IDLE;
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      fill_cnt_q  <= '0;
      cmd_q       <= '0;
      init_done_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      cmd_q       <= cmd_d;
      init_done_q <= init_done_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign init_done = init_done_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_output_ctrl.sv
// ============================================================================
// tb_ram_output_ctrl : directed bench for ram_output_ctrl with a behavioural
//                      registered-address RAM                      (rev 1.0)
// ============================================================================
`default_nettype none

module tb_ram_output_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          req0   = 1'b0;
  logic          we0    = 1'b0;
  logic [AW-1:0] addr0  = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          req1   = 1'b0;
  logic          we1    = 1'b0;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          ack0, ack1, init_done, ram_we;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] addr_reg   = '0;
  logic          mem_seeded = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_output_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .init_done (init_done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_q     (ram_q)
  );

  // RAM starts with a non-zero pattern so a skipped fill address shows up.
  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h5C;
      mem_seeded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end
    addr_reg <= ram_addr;
  end
  assign ram_q = mem[addr_reg];

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          e_ack0, e_ack1, e_we;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic r1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic e0, input logic e1, input logic ewe,
                              input logic [DW-1:0] erd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.e_ack0 = e0; v.e_ack1 = e1; v.e_we = ewe; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int first;
    int who;

    // Inputs are applied at a negedge; outputs are checked at the next negedge.
    tbl[0]  = mk(0,0,4'd0,8'h00, 1,0,4'd15,8'h00, 0,0,0,8'h00);
    tbl[1]  = mk(0,0,4'd0,8'h00, 1,0,4'd15,8'h00, 0,0,0,8'h00);
    tbl[2]  = mk(0,0,4'd0,8'h00, 1,0,4'd15,8'h00, 0,1,0,8'h00);
    tbl[3]  = mk(0,0,4'd0,8'h00, 0,0,4'd0, 8'h00, 0,0,0,8'h00);
    tbl[4]  = mk(1,1,4'd3,8'hA5, 0,0,4'd0, 8'h00, 0,0,1,8'h00);
    tbl[5]  = mk(1,1,4'd3,8'hA5, 0,0,4'd0, 8'h00, 1,0,0,8'h00);
    tbl[6]  = mk(0,0,4'd3,8'h00, 0,0,4'd0, 8'h00, 0,0,0,8'h00);
    tbl[7]  = mk(1,0,4'd3,8'h00, 0,0,4'd0, 8'h00, 0,0,0,8'h00);
    tbl[8]  = mk(1,0,4'd3,8'h00, 0,0,4'd0, 8'h00, 0,0,0,8'h00);
    tbl[9]  = mk(1,0,4'd3,8'h00, 0,0,4'd0, 8'h00, 1,0,0,8'hA5);
    tbl[10] = mk(0,0,4'd0,8'h00, 0,0,4'd0, 8'h00, 0,0,0,8'hA5);
    tbl[11] = mk(1,1,4'd1,8'h11, 1,1,4'd2, 8'h22, 0,0,1,8'hA5);
`ifdef RAM_OUTPUT_CTRL_RR_EN
    // Last winner was 0, so requester 1 takes the tie.
    tbl[12] = mk(1,1,4'd1,8'h11, 1,1,4'd2, 8'h22, 0,1,0,8'hA5);
    tbl[13] = mk(1,1,4'd1,8'h11, 0,0,4'd0, 8'h00, 0,0,1,8'hA5);
    tbl[14] = mk(1,1,4'd1,8'h11, 0,0,4'd0, 8'h00, 1,0,0,8'hA5);
    first = 1;
`else
    tbl[12] = mk(1,1,4'd1,8'h11, 1,1,4'd2, 8'h22, 1,0,0,8'hA5);
    tbl[13] = mk(0,0,4'd0,8'h00, 1,1,4'd2, 8'h22, 0,0,1,8'hA5);
    tbl[14] = mk(0,0,4'd0,8'h00, 1,1,4'd2, 8'h22, 0,1,0,8'hA5);
    first = 0;
`endif
    tbl[15] = mk(0,0,4'd0,8'h00, 0,0,4'd0, 8'h00, 0,0,0,8'hA5);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    rst_n = 1'b1;

    // Zero-fill; req1 raised mid-fill must wait for init_done
    for (int k = 1; k <= 17; k++) begin
      if (k == 5) begin
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd15;
      end
      @(negedge clk);
      if (k <= 16) begin
        chk($sformatf("fill%0d_we", k), ram_we, 1);
        chk($sformatf("fill%0d_addr", k), ram_addr, k - 1);
        chk($sformatf("fill%0d_data", k), ram_data, 0);
        chk($sformatf("fill%0d_done", k), init_done, 0);
      end else begin
        chk("init_done", init_done, 1);
        chk("post_fill_we", ram_we, 0);
      end
      chk($sformatf("fill%0d_ack1", k), ack1, 0);
    end

    // Table: unfilled read @15, write/read @3, simultaneous writes
    for (int i = 0; i < 16; i++) begin
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d_ack0", i), ack0, tbl[i].e_ack0);
      chk($sformatf("vec%0d_ack1", i), ack1, tbl[i].e_ack1);
      chk($sformatf("vec%0d_ram_we", i), ram_we, tbl[i].e_we);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
    end

    // Both requesters hold reads: one ack every 3 cycles, alternating
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      who = first ^ (((k / 3) - 1) & 1);
      chk($sformatf("rr%0d_ack0", k), ack0, ((k % 3) == 0) && (who == 0));
      chk($sformatf("rr%0d_ack1", k), ack1, ((k % 3) == 0) && (who == 1));
      chk($sformatf("rr%0d_ram_we", k), ram_we, 0);
      if ((k % 3) == 0) chk($sformatf("rr%0d_rdata", k), rdata, (who == 1) ? 8'h22 : 8'h11);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);

    // Reset while in RD_WAIT
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd1;
    @(negedge clk);
    @(negedge clk);
    chk("rdwait_ack1", ack1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_ack1", ack1, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_init_done", init_done, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_ram_addr", ram_addr, 0);
    req1 = 1'b0;
    @(negedge clk);
    chk("abort_hold_ack1", ack1, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("refill%0d_we", k), ram_we, 1);
      chk($sformatf("refill%0d_addr", k), ram_addr, k - 1);
      chk($sformatf("refill%0d_ack1", k), ack1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
